// File: rtl/seven_pkg.sv
// Shared constants and types for the seven-segment readback path.
package seven_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned DIGITS   = 4;

    // Segment patterns, bits {a,b,c,d,e,f,g}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h47;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    localparam logic [15:0][SEG_W-1:0] SEG_MAP = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PATTERN = 2'b01;
    localparam logic [1:0] ERR_SELECT  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef struct packed {
        logic [NIBBLE_W-1:0] nibble;
        logic                blank;
        logic                ok;
    } seg_dec_t;

endpackage

// File: rtl/seven_if.sv
// Segment-bus capture interface: display-side inputs plus decoded readback.
interface seven_if;
    logic        enable;
    logic [7:0]  seg_in;
    logic [3:0]  dig_in;
    logic [15:0] value;
    logic        valid;
    logic        blank;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        output enable, seg_in, dig_in,
        input  value, valid, blank, err, err_code
    );

    modport slave (
        input  enable, seg_in, dig_in,
        output value, valid, blank, err, err_code
    );
endinterface

// File: rtl/segdigit_decode.sv
// Inverse of the display-side digit encoder: segment pattern to {nibble, blank, ok}.
module segdigit_decode
    import seven_pkg::*;
(
    input  logic [7:0] seg,
    output seg_dec_t   dec
);

    logic unused_dp;
    assign unused_dp = seg[0];

    always_comb begin
        dec = '0;
        if (seg[7:1] == SEG_BLANK) begin
            dec.blank = 1'b1;
            dec.ok    = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg[7:1] == SEG_MAP[i]) begin
                    dec.nibble = NIBBLE_W'(i);
                    dec.ok     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seven_reader.sv
// Samples a multiplexed 4-digit seven-segment bus, debounces each digit and
// reassembles the displayed 16-bit word, flagging blank words and bus errors.
module seven_reader
    import seven_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic    clk,
    input  logic    rst_n,
    seven_if.slave  bus
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMO_W = 16;

    logic [7:0]                      seg_s1, seg_s2, seg_p;
    logic [3:0]                      dig_s1, dig_s2, dig_p;
    logic [CNT_W-1:0]                stab_cnt, cnt_nxt;
    logic                            armed;
    logic [TMO_W-1:0]                tmo_cnt;
    state_t                          state;
    logic [DIGITS-1:0]               mask, mask_nxt;
    logic [DIGITS-1:0][NIBBLE_W-1:0] slot_nib, slot_nib_nxt;
    logic [DIGITS-1:0]               slot_blank, slot_blank_nxt;
    logic [15:0]                     value_r;
    logic                            valid_r, blank_r, err_r;
    logic [1:0]                      err_code_r;
    seg_dec_t                        dec;

    logic same, accept, onehot, good, bad_sel, bad_pat, tmo_hit;

    segdigit_decode u_decode (
        .seg (seg_s2),
        .dec (dec)
    );

    // Stability tracking and classification of the accepted sample
    always_comb begin
        same    = ({seg_s2, dig_s2} == {seg_p, dig_p});
        cnt_nxt = !same ? CNT_W'(1)
                : (stab_cnt == CNT_W'(STABLE_CYCLES)) ? stab_cnt
                : stab_cnt + CNT_W'(1);
        accept  = armed && same && (cnt_nxt == CNT_W'(STABLE_CYCLES));
        onehot  = (dig_s2 != 4'd0) && ((dig_s2 & (dig_s2 - 4'd1)) == 4'd0);
        good    = accept && onehot && dec.ok;
        bad_sel = accept && (dig_s2 != 4'd0) && !onehot;
        bad_pat = accept && onehot && !dec.ok;
        tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
    end

    // Slot contents as they would be after writing the current digit
    always_comb begin
        slot_nib_nxt   = slot_nib;
        slot_blank_nxt = slot_blank;
        mask_nxt       = mask;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (dig_s2[i]) begin
                slot_nib_nxt[i]   = dec.nibble;
                slot_blank_nxt[i] = dec.blank;
                mask_nxt[i]       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1     <= '0;
            seg_s2     <= '0;
            seg_p      <= '0;
            dig_s1     <= '0;
            dig_s2     <= '0;
            dig_p      <= '0;
            stab_cnt   <= '0;
            armed      <= 1'b1;
            tmo_cnt    <= '0;
            state      <= IDLE;
            mask       <= '0;
            slot_nib   <= '0;
            slot_blank <= '0;
            value_r    <= '0;
            valid_r    <= 1'b0;
            blank_r    <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            seg_s1   <= bus.seg_in;
            seg_s2   <= seg_s1;
            dig_s1   <= bus.dig_in;
            dig_s2   <= dig_s1;
            seg_p    <= seg_s2;
            dig_p    <= dig_s2;
            stab_cnt <= cnt_nxt;

            if (!same) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end

            valid_r <= 1'b0;
            err_r   <= 1'b0;

            if (!bus.enable) begin
                state   <= IDLE;
                mask    <= '0;
                tmo_cnt <= '0;
            end else begin
                // Pattern/select faults never touch the mask; timeout below overrides the code
                if (state != DONE && (bad_sel || bad_pat)) begin
                    err_r      <= 1'b1;
                    err_code_r <= bad_sel ? ERR_SELECT : ERR_PATTERN;
                end

                case (state)
                    IDLE: begin
                        if (good) begin
                            slot_nib   <= slot_nib_nxt;
                            slot_blank <= slot_blank_nxt;
                            mask       <= mask_nxt;
                            tmo_cnt    <= '0;
                            state      <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (good) begin
                            slot_nib   <= slot_nib_nxt;
                            slot_blank <= slot_blank_nxt;
                            mask       <= mask_nxt;
                        end
                        // Completion takes priority over a coincident timeout
                        if (good && (mask_nxt == '1)) begin
                            value_r <= slot_nib_nxt;
                            blank_r <= &slot_blank_nxt;
                            valid_r <= 1'b1;
                            state   <= DONE;
                        end else if (tmo_hit) begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_TIMEOUT;
                            mask       <= '0;
                            state      <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    DONE: begin
                        mask  <= '0;
                        state <= IDLE;
                    end
                    default: begin
                        mask  <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.value    = value_r;
    assign bus.valid    = valid_r;
    assign bus.blank    = blank_r;
    assign bus.err      = err_r;
    assign bus.err_code = err_code_r;

endmodule

// File: tb/tb_seven_reader.sv
// Directed bench for seven_reader: scans, blanks, faults, timeout, enable and reset.
module tb_seven_reader;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   valid_cnt = 0;
    int   err_cnt   = 0;
    logic [1:0] last_code = 2'b00;

    seven_if bus ();

    seven_reader #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (bus.valid === 1'b1) valid_cnt++;
        if (bus.err === 1'b1) begin
            err_cnt++;
            last_code = bus.err_code;
        end
    end

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'h0: pat = 7'h7E;  4'h1: pat = 7'h30;  4'h2: pat = 7'h6D;  4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;  4'h5: pat = 7'h5B;  4'h6: pat = 7'h5F;  4'h7: pat = 7'h70;
            4'h8: pat = 7'h7F;  4'h9: pat = 7'h7B;  4'hA: pat = 7'h77;  4'hB: pat = 7'h1F;
            4'hC: pat = 7'h4E;  4'hD: pat = 7'h3D;  4'hE: pat = 7'h4F;  default: pat = 7'h47;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] p, input logic [3:0] d, input int n);
        bus.seg_in = {p, 1'b0};
        bus.dig_in = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) begin
            drive(pat(w[i*4 +: 4]), 4'(1 << i), 8);
        end
        drive(7'h00, 4'b0000, 8);
    endtask

    initial begin
        int lat;
        int cyc;

        rst_n      = 1'b0;
        bus.enable = 1'b1;
        bus.seg_in = '0;
        bus.dig_in = '0;
        repeat (3) @(negedge clk);
        check("rst_value", 32'(bus.value), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_blank", 32'(bus.blank), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_err_code", 32'(bus.err_code), 32'h0);
        rst_n = 1'b1;
        drive(7'h00, 4'b0000, 6);

        // Scan 0x1A3F, measuring latency of the last digit
        drive(pat(4'h1), 4'b1000, 8);
        drive(pat(4'hA), 4'b0100, 8);
        drive(pat(4'h3), 4'b0010, 8);
        bus.seg_in = {pat(4'hF), 1'b0};
        bus.dig_in = 4'b0001;
        lat = 0;
        cyc = 0;
        while (lat == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.valid === 1'b1) lat = cyc;
        end
        check("latency", 32'(lat), 32'd6);
        @(negedge clk);
        check("valid_one_cycle", 32'(bus.valid), 32'h0);
        check("scan1_value", 32'(bus.value), 32'h1A3F);
        check("scan1_blank", 32'(bus.blank), 32'h0);
        drive(7'h00, 4'b0000, 8);
        check("scan1_valid_cnt", 32'(valid_cnt), 32'd1);
        check("scan1_err_cnt", 32'(err_cnt), 32'd0);

        // All digits blank
        for (int i = 3; i >= 0; i--) drive(7'h00, 4'(1 << i), 8);
        drive(7'h00, 4'b0000, 8);
        check("blank_valid_cnt", 32'(valid_cnt), 32'd2);
        check("blank_value", 32'(bus.value), 32'h0);
        check("blank_flag", 32'(bus.blank), 32'h1);

        // Bad pattern on d1, then repaired; other slots must survive
        drive(pat(4'h5), 4'b1000, 8);
        drive(pat(4'h6), 4'b0100, 8);
        drive(7'h7C, 4'b0010, 8);
        drive(pat(4'hC), 4'b0001, 8);
        drive(7'h00, 4'b0000, 8);
        check("badpat_err_cnt", 32'(err_cnt), 32'd1);
        check("badpat_code", 32'(last_code), 32'h1);
        check("badpat_no_valid", 32'(valid_cnt), 32'd2);
        drive(pat(4'h3), 4'b0010, 8);
        drive(7'h00, 4'b0000, 8);
        check("repair_valid_cnt", 32'(valid_cnt), 32'd3);
        check("repair_value", 32'(bus.value), 32'h563C);
        check("repair_blank", 32'(bus.blank), 32'h0);

        // Non-one-hot select
        drive(pat(4'h1), 4'b0011, 8);
        drive(7'h00, 4'b0000, 8);
        check("badsel_err_cnt", 32'(err_cnt), 32'd2);
        check("badsel_code", 32'(last_code), 32'h2);

        // 2-cycle glitch on d3 is never accepted, so three digits time out
        drive(pat(4'h1), 4'b1000, 2);
        drive(7'h00, 4'b0000, 8);
        drive(pat(4'hA), 4'b0100, 8);
        drive(pat(4'h3), 4'b0010, 8);
        drive(pat(4'hF), 4'b0001, 8);
        drive(7'h00, 4'b0000, 3);
        check("glitch_no_valid", 32'(valid_cnt), 32'd3);
        check("glitch_no_err", 32'(err_cnt), 32'd2);
        drive(7'h00, 4'b0000, 120);
        check("timeout_err_cnt", 32'(err_cnt), 32'd3);
        check("timeout_code", 32'(last_code), 32'h3);
        check("timeout_no_valid", 32'(valid_cnt), 32'd3);
        scan(16'h2468);
        check("after_tmo_valid_cnt", 32'(valid_cnt), 32'd4);
        check("after_tmo_value", 32'(bus.value), 32'h2468);

        // Disable mid-word discards the collected digits
        drive(pat(4'h1), 4'b1000, 8);
        drive(pat(4'h2), 4'b0100, 8);
        bus.enable = 1'b0;
        drive(7'h00, 4'b0000, 4);
        check("disable_value_held", 32'(bus.value), 32'h2468);
        bus.enable = 1'b1;
        drive(pat(4'h3), 4'b0010, 8);
        drive(pat(4'h4), 4'b0001, 8);
        drive(7'h00, 4'b0000, 8);
        check("disable_no_valid", 32'(valid_cnt), 32'd4);
        drive(7'h00, 4'b0000, 120);
        check("disable_tmo_err_cnt", 32'(err_cnt), 32'd4);
        check("disable_tmo_code", 32'(last_code), 32'h3);

        // Reset after two digits, then a clean scan of 0xBEEF
        drive(pat(4'h9), 4'b1000, 8);
        drive(pat(4'h8), 4'b0100, 8);
        rst_n      = 1'b0;
        bus.seg_in = '0;
        bus.dig_in = '0;
        #1;
        check("midrst_value", 32'(bus.value), 32'h0);
        check("midrst_blank", 32'(bus.blank), 32'h0);
        check("midrst_valid", 32'(bus.valid), 32'h0);
        check("midrst_err", 32'(bus.err), 32'h0);
        check("midrst_err_code", 32'(bus.err_code), 32'h0);
        drive(7'h00, 4'b0000, 2);
        rst_n = 1'b1;
        drive(7'h00, 4'b0000, 4);
        scan(16'hBEEF);
        check("beef_value", 32'(bus.value), 32'hBEEF);
        check("beef_blank", 32'(bus.blank), 32'h0);
        check("beef_valid_cnt", 32'(valid_cnt), 32'd5);
        check("beef_err_cnt", 32'(err_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
